// File: rtl/fir_out_collector.sv
// Output collector for the FIR result stream: FWFT FIFO toward the downstream
// consumer plus per-frame statistics exposed on a read-only AXI-Lite port.
module fir_out_collector #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8
) (
  input  logic                      axis_clk,
  input  logic                      axis_rst_n,
  input  logic                      s_tvalid,
  input  logic [pDATA_WIDTH-1:0]    s_tdata,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic                      m_tvalid,
  output logic [pDATA_WIDTH-1:0]    m_tdata,
  output logic                      m_tlast,
  input  logic                      m_tready,
  input  logic                      arvalid,
  input  logic [pADDR_WIDTH-1:0]    araddr,
  output logic                      arready,
  output logic                      rvalid,
  output logic [pDATA_WIDTH-1:0]    rdata,
  input  logic                      rready,
  output logic [$clog2(pDEPTH):0]   level
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(pDEPTH);

  localparam logic [pADDR_WIDTH-1:0] REG_STATUS = pADDR_WIDTH'('h00);
  localparam logic [pADDR_WIDTH-1:0] REG_FCNT   = pADDR_WIDTH'('h04);
  localparam logic [pADDR_WIDTH-1:0] REG_FSUM   = pADDR_WIDTH'('h08);
  localparam logic [pADDR_WIDTH-1:0] REG_FRAMES = pADDR_WIDTH'('h0C);
  localparam logic [pADDR_WIDTH-1:0] REG_LEVEL  = pADDR_WIDTH'('h10);

  // Two's-complement accumulate; the checksum wraps by construction.
  function automatic logic signed [pDATA_WIDTH-1:0] wrap_add(
    input logic signed [pDATA_WIDTH-1:0] a,
    input logic signed [pDATA_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  logic [pDATA_WIDTH:0] mem [pDEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;

  logic [pDATA_WIDTH-1:0]        run_cnt;
  logic signed [pDATA_WIDTH-1:0] run_sum;
  logic [pDATA_WIDTH-1:0]        frame_cnt;
  logic signed [pDATA_WIDTH-1:0] frame_sum;
  logic [pDATA_WIDTH-1:0]        frames;
  logic                          done;

  logic                   ar_hs;
  logic [pDATA_WIDTH-1:0] rd_sel;

  assign fifo_full  = (level == FULL_LVL);
  assign fifo_empty = (level == '0);
  assign s_tready   = !fifo_full;
  assign m_tvalid   = !fifo_empty;
  assign push       = s_tvalid && s_tready;
  assign pop        = m_tvalid && m_tready;

  // Head is gated so the outputs read as zero while empty (array is not reset).
  assign m_tdata = m_tvalid ? mem[rd_ptr][pDATA_WIDTH-1:0] : '0;
  assign m_tlast = m_tvalid && mem[rd_ptr][pDATA_WIDTH];

  always_ff @(posedge axis_clk) begin
    if (push) mem[wr_ptr] <= {s_tlast, s_tdata};
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Input-side statistics
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      run_cnt   <= '0;
      run_sum   <= '0;
      frame_cnt <= '0;
      frame_sum <= '0;
      frames    <= '0;
    end else if (push) begin
      if (s_tlast) begin
        frame_cnt <= run_cnt + 1'b1;
        frame_sum <= wrap_add(run_sum, $signed(s_tdata));
        frames    <= frames + 1'b1;
        run_cnt   <= '0;
        run_sum   <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
        run_sum <= wrap_add(run_sum, $signed(s_tdata));
      end
    end
  end

  // A frame completing in the same cycle as a status read keeps done set.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      done <= 1'b0;
    end else if (push && s_tlast) begin
      done <= 1'b1;
    end else if (ar_hs && (araddr == REG_STATUS)) begin
      done <= 1'b0;
    end
  end

  always_comb begin
    rd_sel = '0;
    case (araddr)
      REG_STATUS: rd_sel = {{(pDATA_WIDTH-3){1'b0}}, fifo_full, fifo_empty, done};
      REG_FCNT:   rd_sel = frame_cnt;
      REG_FSUM:   rd_sel = $unsigned(frame_sum);
      REG_FRAMES: rd_sel = frames;
      REG_LEVEL:  rd_sel = pDATA_WIDTH'(level);
      default:    rd_sel = '0;
    endcase
  end

  // Single-outstanding AXI-Lite read channel
  assign arready = !rvalid;
  assign ar_hs   = arvalid && arready;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_sel;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule
